// File: rtl/sindoku_uart_dump.sv
`default_nettype none
// ============================================================================
// Module   : sindoku_uart_dump
// Brief    : Reads the 9x9 sindoku grid through its cell read port and sends it
//            to the host as 99 ASCII bytes (9 cells + CR LF per row), 8N1.
// Revision : 1.0 - initial release
// ============================================================================
module sindoku_uart_dump #(
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       start,
    output logic [3:0] rd_i,
    output logic [3:0] rd_j,
    input  logic [3:0] rd_value,
    output logic       TxD,
    output logic       busy,
    output logic       done
);

    localparam int CNT_MAX = (CLKS_PER_BIT > GAP_CYCLES) ? CLKS_PER_BIT : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    // FETCH absorbs all gap cycles but the final LOAD one; the address is held, so
    // rd_value stays valid however long FETCH lasts.
    localparam logic [CW-1:0] C_GAP_LAST  = CW'(GAP_CYCLES - 2);
    localparam logic [7:0]    C_CR        = 8'h0D;
    localparam logic [7:0]    C_LF        = 8'h0A;
    localparam logic [3:0]    C_LAST_ROW  = 4'd8;
    localparam logic [3:0]    C_K_LF      = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      k_q, k_d;
    logic [3:0]      r_q, r_d;
    logic [3:0]      c_q, c_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [3:0]      rd_i_q, rd_i_d;
    logic [3:0]      rd_j_q, rd_j_d;
    logic            w_baud_last;

    function automatic logic [7:0] map_cell(input logic [3:0] v);
        if (v == 4'd0)
            return 8'h2E;
        else if (v <= 4'd9)
            return 8'h30 + {4'h0, v};
        else
            return 8'h3F;
    endfunction

    assign w_baud_last = (cnt_q == C_BAUD_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_i_d  = rd_i_q;
        rd_j_d  = rd_j_q;

        case (state_q)
            S_IDLE: begin
                // A start coinciding with done is dropped so one pulse never yields two dumps.
                if (start && !done_q) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    rd_i_d  = '0;
                    rd_j_d  = '0;
                end
            end
            S_FETCH: begin
                if (cnt_q == C_GAP_LAST) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD: begin
                if (k_q < 4'd9)
                    shift_d = map_cell(rd_value);
                else if (k_q == 4'd9)
                    shift_d = C_CR;
                else
                    shift_d = C_LF;
                txd_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (w_baud_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    cnt_d = '0;
                    if (r_q == C_LAST_ROW && k_q == C_K_LF) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        r_d     = '0;
                        c_d     = '0;
                        k_d     = '0;
                    end else begin
                        state_d = S_FETCH;
                        if (k_q == C_K_LF) begin
                            k_d = '0;
                            r_d = r_q + 4'd1;
                            c_d = '0;
                        end else begin
                            k_d = k_q + 4'd1;
                            c_d = (k_q < 4'd8) ? (k_q + 4'd1) : c_q;
                        end
                        rd_i_d = r_d;
                        rd_j_d = c_d;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_i_q  <= '0;
            rd_j_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            k_q     <= k_d;
            r_q     <= r_d;
            c_q     <= c_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_i_q  <= rd_i_d;
            rd_j_q  <= rd_j_d;
        end
    end

    assign TxD  = txd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign rd_i = rd_i_q;
    assign rd_j = rd_j_q;

endmodule
`default_nettype wire
